// File: rtl/cabac_rate_pkg.sv
// Shared constants and helpers for the CABAC rate-estimator blocks.
package cabac_rate_pkg;

   // Flags coded per 4x4 sub-block before escape coding takes over.
   localparam int unsigned C1FLAG_NUMBER = 8;
   localparam int unsigned C2FLAG_NUMBER = 1;

   // Base level from the running gt1/gt2 flag indices, unsigned compares.
   // Thresholds default to the HEVC values but can be overridden by callers
   // that are parameterised differently.
   function automatic logic [1:0] calc_base_level(
      input logic [31:0] c1_idx,
      input logic [31:0] c2_idx,
      input int unsigned c1_num = C1FLAG_NUMBER,
      input int unsigned c2_num = C2FLAG_NUMBER
   );
      logic [1:0] lvl;
      if (c1_idx >= c1_num)      lvl = 2'd1;
      else if (c2_idx >= c2_num) lvl = 2'd2;
      else                       lvl = 2'd3;
      return lvl;
   endfunction

endpackage

// File: rtl/base_level_calc.sv
// Registered base-level calculator: one request per start, result plus a
// one-cycle done strobe on the following cycle. No busy state.
module base_level_calc
   import cabac_rate_pkg::*;
#(
   parameter int unsigned IDX_W         = 8,
   parameter int unsigned LVL_W         = 8,
   parameter int unsigned C1FLAG_NUMBER = cabac_rate_pkg::C1FLAG_NUMBER,
   parameter int unsigned C2FLAG_NUMBER = cabac_rate_pkg::C2FLAG_NUMBER
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [IDX_W-1:0] c1Idx,
   input  logic [IDX_W-1:0] c2Idx,
   output logic [LVL_W-1:0] baseLevel,
   output logic             done
);

   logic [1:0]       lvl_raw;
   logic [LVL_W-1:0] lvl_ext;

   // Rule evaluation; result is 1..3 and zero-extended to the output width.
   always_comb begin
      lvl_raw = calc_base_level(32'(c1Idx), 32'(c2Idx), C1FLAG_NUMBER, C2FLAG_NUMBER);
      lvl_ext = LVL_W'(lvl_raw);
   end

   // Capture on start; level holds between requests, done follows start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         baseLevel <= '0;
         done      <= 1'b0;
      end else begin
         done <= start;
         if (start) baseLevel <= lvl_ext;
      end
   end

endmodule

// File: tb/tb_base_level_calc.sv
// Directed bench for base_level_calc with an independent reference model.
module tb_base_level_calc;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [7:0] c1Idx, c2Idx;
   logic [7:0] baseLevel;
   logic       done;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_lvl  = 0;
   int exp_done = 0;
   bit chk_en   = 1'b0;

   base_level_calc dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .c1Idx(c1Idx), .c2Idx(c2Idx),
      .baseLevel(baseLevel), .done(done)
   );

   always #5 clk = ~clk;

   // Reference: count the thresholds still open (gt1 budget, then gt2 budget).
   function automatic int model(input int c1, input int c2);
      int open_c1 = (c1 < 8) ? 1 : 0;
      int open_c2 = (c1 < 8 && c2 < 1) ? 1 : 0;
      return 1 + open_c1 + open_c2;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // One request cycle: inputs driven now, sampled at the next edge.
   task automatic step(input bit s, input int c1, input int c2);
      start = s;
      c1Idx = 8'(c1);
      c2Idx = 8'(c2);
      @(posedge clk);
      #1;
      if (s) exp_lvl = model(c1, c2);
      exp_done = s ? 1 : 0;
   endtask

   // Continuous comparison mid-cycle against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("cmp_lvl", int'(baseLevel), exp_lvl);
         check("cmp_done", int'(done), exp_done);
      end
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; c1Idx = '0; c2Idx = '0;
      chk_en = 1'b1;
      #12;
      check("rst_lvl", int'(baseLevel), 0);
      check("rst_done", int'(done), 0);
      #10; rst_n = 1'b1;   // t=22, first sampling edge at 25

      // Model pins
      check("model_5_0", model(5, 0), 3);
      check("model_7_1", model(7, 1), 2);
      check("model_255_255", model(255, 255), 1);

      // Basic rule
      step(1, 5, 0);   check("basic_5_0", int'(baseLevel), 3);  check("basic_done", int'(done), 1);
      step(1, 3, 4);   check("basic_3_4", int'(baseLevel), 2);
      step(1, 12, 0);  check("basic_12_0", int'(baseLevel), 1);

      // Hold
      step(0, 2, 0);   check("hold_lvl", int'(baseLevel), 1);   check("hold_done", int'(done), 0);
      step(0, 0, 0);   check("hold2_lvl", int'(baseLevel), 1);

      // Boundaries
      step(1, 7, 0);     check("bnd_7_0", int'(baseLevel), 3);
      step(0, 0, 0);
      step(1, 7, 1);     check("bnd_7_1", int'(baseLevel), 2);
      step(0, 0, 0);
      step(1, 8, 0);     check("bnd_8_0", int'(baseLevel), 1);
      step(0, 0, 0);
      step(1, 255, 255); check("bnd_255_255", int'(baseLevel), 1);
      step(0, 0, 0);     check("bnd_done_drop", int'(done), 0);

      // Back-to-back
      step(1, 0, 0);   check("b2b_0", int'(baseLevel), 3); check("b2b_d0", int'(done), 1);
      step(1, 0, 1);   check("b2b_1", int'(baseLevel), 2); check("b2b_d1", int'(done), 1);
      step(1, 9, 0);   check("b2b_2", int'(baseLevel), 1); check("b2b_d2", int'(done), 1);
      step(0, 0, 0);   check("b2b_end", int'(done), 0);

      // Mid-operation reset: pending request lost, clear is immediate
      step(1, 5, 0);   check("mid_pre", int'(baseLevel), 3);
      start = 1'b1; c1Idx = 8'd5; c2Idx = 8'd0;
      #2;
      rst_n = 1'b0; exp_lvl = 0; exp_done = 0;
      #1;
      check("mid_async_lvl", int'(baseLevel), 0);
      check("mid_async_done", int'(done), 0);
      @(posedge clk); #1;
      check("mid_hold_lvl", int'(baseLevel), 0);
      check("mid_hold_done", int'(done), 0);
      rst_n = 1'b1;
      step(0, 5, 0);   check("mid_lost_lvl", int'(baseLevel), 0); check("mid_lost_done", int'(done), 0);
      step(1, 6, 0);   check("mid_after", int'(baseLevel), 3);   check("mid_after_done", int'(done), 1);
      step(0, 0, 0);

      @(negedge clk); #1;
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
